spi_xfer_ctrl: RTL and testbench
================================

Name: spi_xfer_ctrl

Overview:
- Transaction sequencer directly upstream of the SPI byte engine (spi_host).
- Accepts a length-tagged command plus a TX byte stream, buffers the TX bytes, and drives the engine's start/byte handshake one byte at a time.
- Collects each received byte into an RX FIFO and frames the whole transfer with an active-low chip select, with programmable lead and trail gaps.

Parameters:
- TxDepth, 8, TX FIFO entries; power of 2, ≥2.
- RxDepth, 8, RX FIFO entries; power of 2, ≥2.
- CsLeadCycles, 4, clk cycles csb_o is low before the first start_o; ≥1.
- CsTrailCycles, 4, clk cycles csb_o stays low after the last byte completes; ≥1.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-high
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_len_i  in  8  byte count minus 1 (0 → 1 byte, 255 → 256 bytes)
- cmd_keep_cs_i  in  1  1 = keep csb_o low after the transfer (no trail, no release)
- tx_valid_i  in  1  TX byte valid
- tx_ready_o  out  1  TX FIFO not full
- tx_data_i  in  8  TX byte
- rx_valid_o  out  1  RX FIFO not empty
- rx_ready_i  in  1  RX pop when valid&ready
- rx_data_o  out  8  RX FIFO head
- start_o  out  1  to engine start_i
- tx_byte_o  out  8  to engine byte_data_i
- rx_byte_i  in  8  from engine byte_data_o
- byte_done_i  in  1  from engine next_tx_byte_o; level, may stay high for several clk cycles
- csb_o  out  1  SPI chip select, active-low
- busy_o  out  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values:
  - csb_o=1
  - start_o=0, tx_byte_o=0
  - cmd_ready_o=1, busy_o=0
  - rx_valid_o=0, rx_data_o=0
  - both FIFOs empty (tx_ready_o=1)
  - remaining-byte counter=0, byte_done_q=0, FSM=IDLE
- Reset mid-transfer aborts at once: csb_o=1, start_o=0, buffered data discarded. The engine is reset by the same system reset.
- TX FIFO:
  - Write when tx_valid_i & tx_ready_o.
  - Independent of the FSM; may be pre-filled before a command.
- Done detection:
  - done_pulse = byte_done_i & ~byte_done_q, where byte_done_q is a 1-cycle registered copy.
  - Only done_pulse counts a byte.
  - rx_byte_i is sampled into the RX FIFO in the done_pulse cycle.
- Issue condition (issue_ok):
  - TX FIFO non-empty, AND
  - RX occupancy plus in-flight bytes (0 or 1) < RxDepth.
  - RX overflow is therefore impossible.
- FSM states:
  - IDLE:
    - cmd_ready_o=1.
    - On cmd accept: latch remaining=cmd_len_i+1 (9-bit) and keep_cs.
    - If csb_o is already low (previous keep_cs), go directly to ISSUE. Otherwise drive csb_o=0 and go to LEAD.
  - LEAD: count CsLeadCycles cycles, then go to ISSUE.
  - ISSUE:
    - When issue_ok: pop TX head into tx_byte_o, set start_o=1, go to XFER.
    - Otherwise wait with start_o=0 (bus stalls with sck idle; csb_o stays low).
  - XFER:
    - start_o and tx_byte_o are held stable until done_pulse.
    - On done_pulse: push rx_byte_i and decrement remaining.
    - If remaining becomes 0: start_o=0, go to TRAIL, or to IDLE if keep_cs.
    - Else if issue_ok (evaluated excluding the byte just completed from in-flight): pop the next byte into tx_byte_o in the same cycle, keep start_o=1 (back-to-back), stay in XFER.
    - Else: start_o=0, go to ISSUE.
  - TRAIL: count CsTrailCycles cycles, then csb_o=1, go to IDLE.
- keep_cs:
  - csb_o stays low through IDLE.
  - The next command skips LEAD.
  - A command with keep_cs=0 ends with TRAIL and release.
- Simultaneous events:
  - TX write and pop in the same cycle: both take effect; occupancy unchanged.
  - RX push and pop in the same cycle: both take effect; push when full cannot occur.
  - cmd_valid_i while busy: ignored (cmd_ready_o=0).
- Data order: FIFO order, MSB-first per byte (handled by the engine).
- Counter: 9-bit remaining counter, so 256 bytes is supported; no wrap.

Test Plan:
- Single byte: reset; write TX 0xA5; cmd len=0, keep_cs=0; engine model returns 0x3C.
  → csb_o falls, start_o rises 4 cycles later with tx_byte_o=0xA5, one done_pulse, rx_data_o=0x3C, csb_o rises 4 cycles after done, busy_o=0.
- Back-to-back: prefill 0x01..0x04; cmd len=3; engine echoes.
  → start_o stays high across all 4 bytes; tx_byte_o updates on each done_pulse; RX reads 0x01..0x04.
- TX underrun: cmd len=2 with only 1 byte queued; write the 2nd byte 50 cycles later.
  → start_o drops after byte 1, csb_o stays low, byte 2 issues the cycle after the write, then 3rd byte likewise.
- RX backpressure: RxDepth=8, cmd len=11, rx_ready_i=0.
  → exactly 8 bytes complete and start_o stays 0; after 4 pops the remaining 4 complete with no data loss.
- Long done level and keep_cs: byte_done_i held high 6 cycles per byte, cmd len=1 keep_cs=1, then a 2nd cmd len=0 keep_cs=0.
  → exactly 2 RX pushes for the first cmd; csb_o stays low between commands; no LEAD for the 2nd; release after TRAIL.
- Mid-transfer reset: assert rst_i during byte 3 of 5.
  → same-cycle csb_o=1, start_o=0, rx_valid_o=0, tx_ready_o=1; a new command after reset runs normally.

Source files
------------

// File: rtl/spi_xfer_ctrl.sv
// SPI transfer sequencer: buffers TX bytes, feeds the byte engine one byte at a time,
// collects RX bytes and frames the transfer with an active-low chip select.
//
// state | meaning
// IDLE  | waiting for a command; csb_o may still be low from a keep_cs command
// LEAD  | csb_o low, counting the lead gap before the first byte
// ISSUE | waiting for a TX byte and RX room before starting a byte
// XFER  | byte in flight at the engine, start_o and tx_byte_o held
// TRAIL | last byte done, counting the trail gap before releasing csb_o
module spi_xfer_ctrl #(
   parameter int unsigned TxDepth       = 8,
   parameter int unsigned RxDepth       = 8,
   parameter int unsigned CsLeadCycles  = 4,
   parameter int unsigned CsTrailCycles = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       cmd_valid_i,
   output logic       cmd_ready_o,
   input  logic [7:0] cmd_len_i,
   input  logic       cmd_keep_cs_i,
   input  logic       tx_valid_i,
   output logic       tx_ready_o,
   input  logic [7:0] tx_data_i,
   output logic       rx_valid_o,
   input  logic       rx_ready_i,
   output logic [7:0] rx_data_o,
   output logic       start_o,
   output logic [7:0] tx_byte_o,
   input  logic [7:0] rx_byte_i,
   input  logic       byte_done_i,
   output logic       csb_o,
   output logic       busy_o
);

   localparam int unsigned TxAw     = $clog2(TxDepth);
   localparam int unsigned RxAw     = $clog2(RxDepth);
   localparam int unsigned TimerMax = (CsLeadCycles > CsTrailCycles) ? CsLeadCycles : CsTrailCycles;
   localparam int unsigned TimerW   = $clog2(TimerMax + 1);
   // The ISSUE cycle is the last lead cycle, so LEAD itself runs CsLeadCycles-1 cycles.
   localparam logic [TimerW-1:0] LeadLoad  = TimerW'((CsLeadCycles > 1) ? CsLeadCycles - 2 : 0);
   localparam logic [TimerW-1:0] TrailLoad = TimerW'(CsTrailCycles - 1);

   typedef enum logic [2:0] {IDLE, LEAD, ISSUE, XFER, TRAIL} state_e;

   state_e            state_q, state_d;
   logic              csb_q, csb_d;
   logic              start_q, start_d;
   logic [7:0]        tx_byte_q, tx_byte_d;
   logic [8:0]        remaining_q, remaining_d;
   logic              keep_cs_q, keep_cs_d;
   logic [TimerW-1:0] timer_q, timer_d;
   logic              byte_done_q;
   logic              done_pulse;
   logic              issue_ok;
   logic              in_flight;

   logic [7:0]      tx_mem [TxDepth];
   logic [TxAw-1:0] tx_wptr, tx_rptr;
   logic [TxAw:0]   tx_count;
   logic            tx_wr, tx_pop;

   logic [7:0]      rx_mem [RxDepth];
   logic [RxAw-1:0] rx_wptr, rx_rptr;
   logic [RxAw:0]   rx_count;
   logic [RxAw+1:0] rx_level;
   logic            rx_push, rx_pop;

   assign tx_ready_o = (tx_count != (TxAw+1)'(TxDepth));
   assign tx_wr      = tx_valid_i & tx_ready_o;

   always_ff @(posedge clk_i) begin
      if (tx_wr) tx_mem[tx_wptr] <= tx_data_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tx_wptr  <= '0;
         tx_rptr  <= '0;
         tx_count <= '0;
      end else begin
         if (tx_wr)  tx_wptr <= tx_wptr + TxAw'(1);
         if (tx_pop) tx_rptr <= tx_rptr + TxAw'(1);
         case ({tx_wr, tx_pop})
            2'b10:   tx_count <= tx_count + (TxAw+1)'(1);
            2'b01:   tx_count <= tx_count - (TxAw+1)'(1);
            default: tx_count <= tx_count;
         endcase
      end
   end

   assign rx_valid_o = (rx_count != '0);
   assign rx_pop     = rx_valid_o & rx_ready_i;
   assign rx_data_o  = rx_valid_o ? rx_mem[rx_rptr] : 8'h00;

   always_ff @(posedge clk_i) begin
      if (rx_push) rx_mem[rx_wptr] <= rx_byte_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rx_wptr  <= '0;
         rx_rptr  <= '0;
         rx_count <= '0;
      end else begin
         if (rx_push) rx_wptr <= rx_wptr + RxAw'(1);
         if (rx_pop)  rx_rptr <= rx_rptr + RxAw'(1);
         case ({rx_push, rx_pop})
            2'b10:   rx_count <= rx_count + (RxAw+1)'(1);
            2'b01:   rx_count <= rx_count - (RxAw+1)'(1);
            default: rx_count <= rx_count;
         endcase
      end
   end

   // A byte in XFER still owns an RX slot until its push lands, so RX can never overflow.
   assign in_flight  = (state_q == XFER);
   assign rx_level   = {1'b0, rx_count} + {{(RxAw+1){1'b0}}, in_flight};
   assign issue_ok   = (tx_count != '0) && (rx_level < (RxAw+2)'(RxDepth));
   assign done_pulse = byte_done_i & ~byte_done_q;

   always_comb begin
      state_d     = state_q;
      csb_d       = csb_q;
      start_d     = start_q;
      tx_byte_d   = tx_byte_q;
      remaining_d = remaining_q;
      keep_cs_d   = keep_cs_q;
      timer_d     = timer_q;
      tx_pop      = 1'b0;
      rx_push     = 1'b0;
      cmd_ready_o = 1'b0;
      case (state_q)
         IDLE: begin
            cmd_ready_o = 1'b1;
            if (cmd_valid_i) begin
               remaining_d = {1'b0, cmd_len_i} + 9'd1;
               keep_cs_d   = cmd_keep_cs_i;
               csb_d       = 1'b0;
               timer_d     = LeadLoad;
               if (!csb_q || (CsLeadCycles < 2)) state_d = ISSUE;
               else                              state_d = LEAD;
            end
         end
         LEAD: begin
            if (timer_q == '0) state_d = ISSUE;
            else               timer_d = timer_q - TimerW'(1);
         end
         ISSUE: begin
            if (issue_ok) begin
               tx_pop    = 1'b1;
               tx_byte_d = tx_mem[tx_rptr];
               start_d   = 1'b1;
               state_d   = XFER;
            end
         end
         XFER: begin
            if (done_pulse) begin
               rx_push     = 1'b1;
               remaining_d = remaining_q - 9'd1;
               if (remaining_q == 9'd1) begin
                  start_d = 1'b0;
                  timer_d = TrailLoad;
                  state_d = keep_cs_q ? IDLE : TRAIL;
               end else if (issue_ok) begin
                  tx_pop    = 1'b1;
                  tx_byte_d = tx_mem[tx_rptr];
               end else begin
                  start_d = 1'b0;
                  state_d = ISSUE;
               end
            end
         end
         TRAIL: begin
            if (timer_q == '0) begin
               csb_d   = 1'b1;
               state_d = IDLE;
            end else begin
               timer_d = timer_q - TimerW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         csb_q       <= 1'b1;
         start_q     <= 1'b0;
         tx_byte_q   <= 8'h00;
         remaining_q <= 9'd0;
         keep_cs_q   <= 1'b0;
         timer_q     <= '0;
         byte_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         csb_q       <= csb_d;
         start_q     <= start_d;
         tx_byte_q   <= tx_byte_d;
         remaining_q <= remaining_d;
         keep_cs_q   <= keep_cs_d;
         timer_q     <= timer_d;
         byte_done_q <= byte_done_i;
      end
   end

   assign csb_o     = csb_q;
   assign start_o   = start_q;
   assign tx_byte_o = tx_byte_q;
   assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl with a small responder standing in for the SPI byte engine.
module tb_spi_xfer_ctrl;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic       cmd_valid_i;
   logic       cmd_ready_o;
   logic [7:0] cmd_len_i;
   logic       cmd_keep_cs_i;
   logic       tx_valid_i;
   logic       tx_ready_o;
   logic [7:0] tx_data_i;
   logic       rx_valid_o;
   logic       rx_ready_i;
   logic [7:0] rx_data_o;
   logic       start_o;
   logic [7:0] tx_byte_o;
   logic [7:0] rx_byte_i = 8'h00;
   logic       byte_done_i = 1'b0;
   logic       csb_o;
   logic       busy_o;

   always #5 clk_i = ~clk_i;

   spi_xfer_ctrl #(
      .TxDepth(8), .RxDepth(8), .CsLeadCycles(4), .CsTrailCycles(4)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_len_i(cmd_len_i), .cmd_keep_cs_i(cmd_keep_cs_i),
      .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o), .tx_data_i(tx_data_i),
      .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i), .rx_data_o(rx_data_o),
      .start_o(start_o), .tx_byte_o(tx_byte_o), .rx_byte_i(rx_byte_i),
      .byte_done_i(byte_done_i), .csb_o(csb_o), .busy_o(busy_o)
   );

   int total = 0;
   int bad   = 0;

   // engine responder: sees start_o, waits eng_lat cycles, raises done for eng_hold cycles
   int         eng_lat  = 2;
   int         eng_hold = 1;
   int         eng_cnt  = 0;
   logic [7:0] eng_xor  = 8'h00;
   logic [7:0] eng_log[$];

   always begin : engine
      logic [7:0] cur;
      @(posedge clk_i); #1;
      if (start_o === 1'b1 && rst_i === 1'b0) begin
         cur = tx_byte_o;
         eng_log.push_back(cur);
         for (int k = 0; k < eng_lat && !rst_i; k++) begin @(posedge clk_i); #1; end
         if (!rst_i) begin
            rx_byte_i   = cur ^ eng_xor;
            byte_done_i = 1'b1;
            eng_cnt++;
            for (int k = 0; k < eng_hold && !rst_i; k++) begin @(posedge clk_i); #1; end
            byte_done_i = 1'b0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i); #2;
   endtask

   task automatic push_tx(input logic [7:0] d);
      tx_valid_i = 1'b1;
      tx_data_i  = d;
      tick();
      tx_valid_i = 1'b0;
   endtask

   task automatic send_cmd(input logic [7:0] len, input logic keep, input string tag);
      cmd_valid_i   = 1'b1;
      cmd_len_i     = len;
      cmd_keep_cs_i = keep;
      chk({tag, "_cmd_ready"}, cmd_ready_o, 1);
      tick();
      cmd_valid_i = 1'b0;
   endtask

   task automatic pop_rx(input logic [7:0] exp, input string tag);
      chk({tag, "_rx_valid"}, rx_valid_o, 1);
      chk({tag, "_rx_data"}, rx_data_o, exp);
      rx_ready_i = 1'b1;
      tick();
      rx_ready_i = 1'b0;
   endtask

   task automatic wait_cnt(input int target, input string tag);
      int n = 0;
      while (eng_cnt < target && n < 500) begin tick(); n++; end
      chk({tag, "_byte_timeout"}, (n < 500), 1);
   endtask

   task automatic count_lead(input int exp, input string tag);
      int n = 0;
      while (start_o !== 1'b1 && n < 50) begin tick(); n++; end
      chk({tag, "_lead_cycles"}, n, exp);
   endtask

   task automatic count_trail(input int exp, input string tag);
      int n = 0;
      while (csb_o !== 1'b1 && n < 100) begin tick(); n++; end
      chk({tag, "_trail_cycles"}, n, exp);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int base;
      int drops;
      int n;
      cmd_valid_i   = 1'b0;
      cmd_len_i     = 8'h00;
      cmd_keep_cs_i = 1'b0;
      tx_valid_i    = 1'b0;
      tx_data_i     = 8'h00;
      rx_ready_i    = 1'b0;

      // reset values
      repeat (3) tick();
      chk("rst_csb", csb_o, 1);
      chk("rst_start", start_o, 0);
      chk("rst_tx_byte", tx_byte_o, 8'h00);
      chk("rst_cmd_ready", cmd_ready_o, 1);
      chk("rst_busy", busy_o, 0);
      chk("rst_rx_valid", rx_valid_o, 0);
      chk("rst_rx_data", rx_data_o, 8'h00);
      chk("rst_tx_ready", tx_ready_o, 1);
      rst_i = 1'b0;
      tick();

      // single byte
      eng_xor = 8'h99;
      push_tx(8'hA5);
      send_cmd(8'd0, 1'b0, "t1");
      chk("t1_csb_low", csb_o, 0);
      chk("t1_busy", busy_o, 1);
      chk("t1_cmd_ready_busy", cmd_ready_o, 0);
      count_lead(4, "t1");
      chk("t1_tx_byte", tx_byte_o, 8'hA5);
      wait_cnt(1, "t1");
      tick();
      chk("t1_start_off", start_o, 0);
      chk("t1_csb_trail", csb_o, 0);
      count_trail(4, "t1");
      chk("t1_idle", busy_o, 0);
      pop_rx(8'h3C, "t1");
      chk("t1_rx_empty", rx_valid_o, 0);

      // back-to-back, with a command offered while busy
      eng_xor = 8'h00;
      eng_log.delete();
      base = eng_cnt;
      for (int i = 1; i <= 4; i++) push_tx(8'(i));
      send_cmd(8'd3, 1'b0, "t2");
      count_lead(4, "t2");
      cmd_valid_i = 1'b1;
      cmd_len_i   = 8'd0;
      chk("t2_cmd_ignored", cmd_ready_o, 0);
      drops = 0;
      n = 0;
      while (eng_cnt < base + 4 && n < 200) begin
         tick();
         cmd_valid_i = 1'b0;
         n++;
         if (eng_cnt < base + 4 && start_o !== 1'b1) drops++;
      end
      chk("t2_start_drops", drops, 0);
      chk("t2_bytes", eng_cnt - base, 4);
      for (int i = 0; i < 4; i++) chk("t2_tx_order", eng_log[i], i + 1);
      tick();
      count_trail(4, "t2");
      for (int i = 1; i <= 4; i++) pop_rx(8'(i), "t2");
      chk("t2_rx_empty", rx_valid_o, 0);
      chk("t2_no_extra_cmd", busy_o, 0);

      // TX underrun
      base = eng_cnt;
      push_tx(8'h11);
      send_cmd(8'd2, 1'b0, "t3");
      wait_cnt(base + 1, "t3a");
      tick();
      chk("t3_start_drop", start_o, 0);
      chk("t3_csb_held", csb_o, 0);
      repeat (50) tick();
      chk("t3_stalled", start_o, 0);
      chk("t3_stall_cnt", eng_cnt - base, 1);
      push_tx(8'h22);
      chk("t3_b2_not_yet", start_o, 0);
      tick();
      chk("t3_b2_issue", start_o, 1);
      chk("t3_b2_byte", tx_byte_o, 8'h22);
      wait_cnt(base + 2, "t3b");
      tick();
      chk("t3_b3_stall", start_o, 0);
      push_tx(8'h33);
      tick();
      chk("t3_b3_issue", start_o, 1);
      chk("t3_b3_byte", tx_byte_o, 8'h33);
      wait_cnt(base + 3, "t3c");
      tick();
      count_trail(4, "t3");
      pop_rx(8'h11, "t3");
      pop_rx(8'h22, "t3");
      pop_rx(8'h33, "t3");

      // RX backpressure
      base = eng_cnt;
      for (int i = 0; i < 8; i++) push_tx(8'h40 + 8'(i));
      chk("t4_tx_full", tx_ready_o, 0);
      send_cmd(8'd11, 1'b0, "t4");
      wait_cnt(base + 8, "t4a");
      for (int i = 8; i < 12; i++) push_tx(8'h40 + 8'(i));
      repeat (30) tick();
      chk("t4_stop_at_8", eng_cnt - base, 8);
      chk("t4_start_low", start_o, 0);
      chk("t4_csb_low", csb_o, 0);
      for (int i = 0; i < 4; i++) pop_rx(8'h40 + 8'(i), "t4a");
      wait_cnt(base + 12, "t4b");
      tick();
      count_trail(4, "t4");
      repeat (5) tick();
      chk("t4_total", eng_cnt - base, 12);
      for (int i = 4; i < 12; i++) pop_rx(8'h40 + 8'(i), "t4b");
      chk("t4_rx_empty", rx_valid_o, 0);

      // long done level with keep_cs
      eng_hold = 6;
      base = eng_cnt;
      push_tx(8'h51);
      push_tx(8'h52);
      push_tx(8'h53);
      send_cmd(8'd1, 1'b1, "t5a");
      n = 0;
      while (busy_o !== 1'b0 && n < 300) begin tick(); n++; end
      chk("t5_idle_timeout", (n < 300), 1);
      chk("t5_two_bytes", eng_cnt - base, 2);
      chk("t5_csb_kept", csb_o, 0);
      n = 0;
      while (byte_done_i !== 1'b0 && n < 20) begin tick(); n++; end
      repeat (3) tick();
      pop_rx(8'h51, "t5a");
      pop_rx(8'h52, "t5a");
      chk("t5_two_pushes", rx_valid_o, 0);
      chk("t5_csb_between", csb_o, 0);
      send_cmd(8'd0, 1'b0, "t5b");
      chk("t5_busy2", busy_o, 1);
      count_lead(1, "t5_no_lead");
      chk("t5_byte3", tx_byte_o, 8'h53);
      wait_cnt(base + 3, "t5b");
      tick();
      count_trail(4, "t5");
      pop_rx(8'h53, "t5b");
      n = 0;
      while (byte_done_i !== 1'b0 && n < 20) begin tick(); n++; end
      tick();

      // mid-transfer reset
      eng_hold = 1;
      base = eng_cnt;
      for (int i = 0; i < 5; i++) push_tx(8'h61 + 8'(i));
      send_cmd(8'd4, 1'b0, "t6");
      wait_cnt(base + 2, "t6");
      tick();
      chk("t6_in_byte3", start_o, 1);
      chk("t6_byte3", tx_byte_o, 8'h63);
      rst_i = 1'b1;
      #1;
      chk("t6_rst_csb", csb_o, 1);
      chk("t6_rst_start", start_o, 0);
      chk("t6_rst_rx_valid", rx_valid_o, 0);
      chk("t6_rst_tx_ready", tx_ready_o, 1);
      chk("t6_rst_busy", busy_o, 0);
      tick();
      tick();
      rst_i = 1'b0;
      tick();
      chk("t6_post_rx_empty", rx_valid_o, 0);
      eng_xor = 8'h0F;
      base = eng_cnt;
      push_tx(8'h77);
      send_cmd(8'd0, 1'b0, "t6b");
      chk("t6_new_csb", csb_o, 0);
      count_lead(4, "t6b");
      chk("t6_new_byte", tx_byte_o, 8'h77);
      wait_cnt(base + 1, "t6b");
      tick();
      count_trail(4, "t6b");
      pop_rx(8'h78, "t6b");
      chk("t6_rx_empty", rx_valid_o, 0);
      chk("t6_tx_discarded", eng_cnt - base, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
